// File: rtl/viterbi_decoder_param_pkg.sv
// rtl/viterbi_decoder_param_pkg.sv - shared types and trellis helper functions for the Viterbi decoder
package viterbi_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_t;

  // Helpers are written for the widest supported code (K = 7) and take K as an argument.
  localparam int K_MAX = 7;
  localparam int S_MAX = K_MAX - 1;
  localparam int K_DEF = 3;
  localparam int NS    = 2 ** (K_DEF - 1);

  // Successor of state s on input u: newest input enters the MSB of the K-1 bit state.
  function automatic logic [S_MAX-1:0] next_state(input logic [S_MAX-1:0] s, input logic u,
                                                   input int k);
    logic [S_MAX-1:0] r;
    r = s >> 1;
    r[k-2] = u;
    return r;
  endfunction

  // Encoder output {c0, c1} for state s and input u; u sits at bit K-1 of the shift register.
  function automatic logic [1:0] exp_sym(input logic [S_MAX-1:0] s, input logic u,
                                         input logic [K_MAX-1:0] g0, input logic [K_MAX-1:0] g1,
                                         input int k);
    logic [K_MAX-1:0] sr;
    sr = K_MAX'(s);
    sr[k-1] = u;
    return {^(sr & g0), ^(sr & g1)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

endpackage

// File: rtl/viterbi_decoder_param_if.sv
// rtl/viterbi_decoder_param_if.sv - symbol input / decoded bit output bundle of the Viterbi decoder
interface viterbi_decoder_param_if;
  import viterbi_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sym;
  logic       in_last;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;
  logic       busy;

  // Symbol source / bit sink side.
  modport master (
    output in_valid, in_sym, in_last,
    input  in_ready, out_valid, out_bit, out_last, busy
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_sym, in_last,
    output in_ready, out_valid, out_bit, out_last, busy
  );

endinterface

// File: rtl/viterbi_decoder_param_acs.sv
// rtl/viterbi_decoder_param_acs.sv - add-compare-select for one trellis state
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  // Metrics never wrap because the top normalises; a tie keeps predecessor 0 (LSB 0).
  assign cand0  = pm0 + PM_W'(bm0);
  assign cand1  = pm1 + PM_W'(bm1);
  assign dec    = (cand1 < cand0);
  assign pm_new = dec ? cand1 : cand0;

endmodule

// File: rtl/viterbi_decoder_param.sv
// rtl/viterbi_decoder_param.sv - hard-decision rate-1/2 Viterbi decoder with register-exchange survivors
module viterbi_decoder_param
  import viterbi_pkg::*;
#(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = K'(3'b111),
  parameter logic [K-1:0]   G1       = K'(3'b101),
  parameter int             TB_DEPTH = 15,
  parameter int             PM_W     = 6
) (
  input logic                    clk,
  input logic                    reset,
  viterbi_decoder_param_if.slave bus
);

  localparam int              NS_P    = 2 ** (K - 1);
  localparam int              SW      = K - 1;
  localparam int              FW      = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(1) << (PM_W - 2);

  fsm_t                state_q, state_d;
  logic [PM_W-1:0]     pm_q      [NS_P];
  logic [PM_W-1:0]     pm_sum    [NS_P];
  logic [PM_W-1:0]     pm_next   [NS_P];
  logic [TB_DEPTH-1:0] path_q    [NS_P];
  logic [TB_DEPTH-1:0] path_next [NS_P];
  logic [1:0]          bm0       [NS_P];
  logic [1:0]          bm1       [NS_P];
  logic                dec       [NS_P];
  logic [FW-1:0]       fill_q, f_inc, rcnt_q;
  logic                run_vld_q, run_bit_q;
  logic                in_ready, busy, accept, all_msb, flush_bit;
  logic                norm_fire;
  logic [SW-1:0]       best;
  logic [PM_W-1:0]     best_pm;

  assign accept = bus.in_valid & in_ready;
  assign f_inc  = (fill_q == FW'(TB_DEPTH)) ? fill_q : fill_q + FW'(1);

  // One ACS per state; next state {u,t} is reached from {t,0} and {t,1}.
  for (genvar g = 0; g < NS_P; g++) begin : g_state
    localparam logic [SW-1:0] P0 = SW'(g << 1);
    localparam logic [SW-1:0] P1 = SW'((g << 1) | 1);
    localparam logic          U  = 1'((g >> (SW - 1)) & 1);

    assign bm0[g] = hamming2(exp_sym(S_MAX'(P0), U, K_MAX'(G0), K_MAX'(G1), K), bus.in_sym);
    assign bm1[g] = hamming2(exp_sym(S_MAX'(P1), U, K_MAX'(G0), K_MAX'(G1), K), bus.in_sym);

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0    (pm_q[P0]),
      .pm1    (pm_q[P1]),
      .bm0    (bm0[g]),
      .bm1    (bm1[g]),
      .pm_new (pm_sum[g]),
      .dec    (dec[g])
    );

    assign path_next[g] = {dec[g] ? path_q[P1][TB_DEPTH-2:0] : path_q[P0][TB_DEPTH-2:0], U};
  end

  // Normalise: when every new metric has its MSB set, drop that MSB everywhere.
  always_comb begin
    all_msb = 1'b1;
    for (int i = 0; i < NS_P; i++) all_msb = all_msb & pm_sum[i][PM_W-1];
    for (int i = 0; i < NS_P; i++)
      pm_next[i] = all_msb ? {1'b0, pm_sum[i][PM_W-2:0]} : pm_sum[i];
  end

  assign norm_fire = accept & all_msb;

  // Best state over the updated metrics; the lowest index wins a tie.
  always_comb begin
    best    = '0;
    best_pm = pm_sum[0];
    for (int i = 1; i < NS_P; i++) begin
      if (pm_sum[i] < best_pm) begin
        best_pm = pm_sum[i];
        best    = SW'(i);
      end
    end
  end

  // Flush reads state 0's survivor from bit R-1 down to bit 0.
  always_comb begin
    flush_bit = 1'b0;
    for (int i = 0; i < TB_DEPTH; i++)
      if (rcnt_q == FW'(i + 1)) flush_bit = path_q[0][i];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (rcnt_q == FW'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Metrics, survivors, fill/flush counters and the streaming output bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NS_P; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        path_q[i] <= '0;
      end
      fill_q    <= '0;
      rcnt_q    <= '0;
      run_vld_q <= 1'b0;
      run_bit_q <= 1'b0;
    end else begin
      run_vld_q <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NS_P; i++) begin
          pm_q[i]   <= pm_next[i];
          path_q[i] <= path_next[i];
        end
        fill_q <= f_inc;
        if (bus.in_last) begin
          rcnt_q <= f_inc;
        end else if (f_inc == FW'(TB_DEPTH)) begin
          run_vld_q <= 1'b1;
          run_bit_q <= path_next[best][TB_DEPTH-1];
        end
      end else if (state_q == FLUSH) begin
        rcnt_q <= rcnt_q - FW'(1);
        if (rcnt_q == FW'(1)) begin
          for (int i = 0; i < NS_P; i++) begin
            pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
            path_q[i] <= '0;
          end
          fill_q <= '0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = run_vld_q | busy;
  assign bus.out_bit   = busy ? flush_bit : run_bit_q;
  assign bus.out_last  = busy && (rcnt_q == FW'(1));

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// tb/tb_viterbi_decoder_param.sv - directed self-checking bench for viterbi_decoder_param
module tb_viterbi_decoder_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  viterbi_decoder_param_if bus();

  viterbi_decoder_param #(
    .K(3), .G0(3'b111), .G1(3'b101), .TB_DEPTH(15), .PM_W(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    int         n;
    logic [1:0] s [8];
    logic       e [8];
  } vec_t;

  vec_t       vt [5];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       got_q [$];
  logic       last_q [$];
  logic [1:0] tx_q [$];
  logic       exp_q [$];
  int         acc_edge [$];
  int         busy_cnt, run_outs, flush_outs, last_cnt, acc_total, first_out_cyc;
  int         norm_cnt, max_spread, ready_in_busy;
  logic       spread_en = 1'b0;
  logic [1:0] enc_st;

  always @(posedge clk) cyc <= cyc + 1;

  // Output / handshake monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    int mn, mx;
    if (bus.out_valid) begin
      got_q.push_back(bus.out_bit);
      last_q.push_back(bus.out_last);
      if (bus.busy) flush_outs++; else run_outs++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (bus.out_last) last_cnt++;
    end
    if (bus.busy) begin
      busy_cnt++;
      if (bus.in_ready) ready_in_busy++;
    end
    if (bus.in_valid && bus.in_ready) begin
      acc_total++;
      acc_edge.push_back(cyc + 1);
    end
    if (dut.norm_fire) norm_cnt++;
    if (spread_en && !bus.busy) begin
      mn = 1000; mx = 0;
      for (int i = 0; i < 4; i++) begin
        if (int'(dut.pm_q[i]) < mn) mn = int'(dut.pm_q[i]);
        if (int'(dut.pm_q[i]) > mx) mx = int'(dut.pm_q[i]);
      end
      if (mx - mn > max_spread) max_spread = mx - mn;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); last_q.delete(); acc_edge.delete();
    busy_cnt = 0; run_outs = 0; flush_outs = 0; last_cnt = 0;
    first_out_cyc = -1; ready_in_busy = 0;
  endtask

  // Independent K=3 (111,101) encoder; state {newest, older}.
  task automatic encode(input logic u, output logic [1:0] sym);
    sym    = {u ^ enc_st[1] ^ enc_st[0], u ^ enc_st[0]};
    enc_st = {u, enc_st[1]};
  endtask

  task automatic send(input logic [1:0] s, input logic l);
    logic rdy;
    int   guard;
    bus.in_valid = 1'b1;
    bus.in_sym   = s;
    bus.in_last  = l;
    rdy = 1'b0;
    guard = 0;
    while (!rdy && guard < 100) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!rdy) check("send_timeout", 0, 1);
  endtask

  // Send tx_q as one frame and wait for out_last plus the re-init edge.
  task automatic run_frame(input logic hold, input logic spread);
    int n, guard, acc_before;
    n = tx_q.size();
    clear_mon();
    for (int i = 0; i < n; i++) begin
      if (spread && i == 2) spread_en = 1'b1;
      send(tx_q[i], i == n - 1);
    end
    spread_en = 1'b0;
    if (hold) begin
      acc_before = acc_total;
      bus.in_sym  = 2'b11;
      bus.in_last = 1'b0;
      guard = 0;
      while (bus.busy && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      bus.in_valid = 1'b0;
      check("hold_no_accept", acc_total - acc_before, 0);
      check("hold_ready_low", ready_in_busy, 0);
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (last_cnt == 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("frame_done", last_cnt, 1);
  endtask

  task automatic compare_frame(input string pre);
    int n, bad;
    n = exp_q.size();
    check({pre, "_count"}, got_q.size(), n);
    bad = 0;
    for (int i = 0; i < n && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    check({pre, "_bit_errors"}, bad, 0);
    if (last_q.size() == n) check({pre, "_last_pos"}, int'(last_q[n-1]), 1);
    else check({pre, "_last_pos"}, last_q.size(), n);
  endtask

  task automatic load_vec(input int v);
    tx_q.delete(); exp_q.delete();
    for (int i = 0; i < vt[v].n; i++) begin
      tx_q.push_back(vt[v].s[i]);
      exp_q.push_back(vt[v].e[i]);
    end
  endtask

  initial begin
    logic [1:0] sym;
    logic       u;
    int         next_err;

    vt[0] = '{"clean", 6, '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00},
              '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[1] = '{"one_error", 6, '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00},
              '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[2] = '{"zeros", 4, '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00},
              '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[3] = '{"ones_pair", 4, '{2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00},
              '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vt[4] = '{"single_sym", 1, '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00},
              '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};

    acc_total = 0; norm_cnt = 0; max_spread = 0;
    clear_mon();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_sym = 2'b00; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_bit", int'(bus.out_bit), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;

    // Short frames from the vector table.
    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_frame(1'b0, 1'b0);
      compare_frame(vt[v].name);
      check({vt[v].name, "_busy_cycles"}, busy_cnt, vt[v].n);
      check({vt[v].name, "_run_outs"}, run_outs, 0);
    end

    // Streaming: 40 random bits + 2 tail zeros.
    enc_st = 2'b00;
    tx_q.delete(); exp_q.delete();
    for (int i = 0; i < 42; i++) begin
      u = (i < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      encode(u, sym);
      tx_q.push_back(sym);
      exp_q.push_back(u);
    end
    run_frame(1'b0, 1'b0);
    compare_frame("stream");
    check("stream_run_outs", run_outs, 27);
    check("stream_flush_outs", flush_outs, 15);
    if (acc_edge.size() >= 15) check("stream_latency", first_out_cyc, acc_edge[14]);
    else check("stream_accepts", acc_edge.size(), 42);

    // Long frame with isolated symbol errors.
    enc_st = 2'b00;
    tx_q.delete(); exp_q.delete();
    next_err = 5;
    for (int i = 0; i < 2000; i++) begin
      u = (i < 1998) ? 1'($urandom_range(0, 1)) : 1'b0;
      encode(u, sym);
      if (i == next_err) begin
        sym = sym ^ (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
        next_err = next_err + int'($urandom_range(12, 20));
      end
      tx_q.push_back(sym);
      exp_q.push_back(u);
    end
    norm_cnt = 0; max_spread = 0;
    run_frame(1'b0, 1'b1);
    compare_frame("long");
    check("long_norm_fired", int'(norm_cnt > 0), 1);
    check("long_spread_ok", int'(max_spread < 16), 1);

    // in_valid held through FLUSH, then a fresh frame.
    load_vec(0);
    run_frame(1'b1, 1'b0);
    compare_frame("hold_frame");
    load_vec(0);
    run_frame(1'b0, 1'b0);
    compare_frame("after_hold");
    check("after_hold_busy", busy_cnt, 6);

    // Reset mid-frame after 8 symbols.
    enc_st = 2'b00;
    for (int i = 0; i < 8; i++) begin
      encode(1'($urandom_range(0, 1)), sym);
      send(sym, 1'b0);
    end
    bus.in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_bit", int'(bus.out_bit), 0);
    check("midrst_out_last", int'(bus.out_last), 0);
    check("midrst_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    load_vec(0);
    run_frame(1'b0, 1'b0);
    compare_frame("post_reset");
    check("post_reset_busy", busy_cnt, 6);
    check("post_reset_run_outs", run_outs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
